// File: rtl/rv32i_fetch_pkg.sv
// rtl/rv32i_fetch_pkg.sv - shared constants and types for the RV32I fetch unit
// Provides XLEN, the canonical NOP encoding, the fetch FSM state encoding and
// the {pc, instr} buffer entry layout used by the fetch FIFO.
package rv32i_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV32I_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_unit_fifo.sv
// rtl/rv32i_fetch_unit_fifo.sv - registered instruction buffer for the fetch unit
// Module rv32i_fetch_fifo: synchronous FIFO, DEPTH entries (power of 2), no bypass.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push, wdata    write an entry (ignored when full unless a pop happens too)
//   pop            drop the head entry (ignored when empty)
//   flush          empty the buffer; wins over push and pop
//   rdata          head entry, meaningful only while count != 0
//   count          number of valid entries, 0..DEPTH
module rv32i_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL_COUNT) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/rv32i_fetch_unit.sv
// rtl/rv32i_fetch_unit.sv - RV32I instruction fetch front end
// Holds the fetch PC, issues one word request at a time to instruction memory,
// buffers returned words with their PC and hands them to the decoder.
// Optional feature macro: RV32I_FETCH_MISALIGN_EN (misaligned redirect fault).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   imemReq/imemAddr/imemGnt    request channel, address held until grant
//   imemRvalid/imemRdata        in-order read response
//   redirectValid/redirectPc    new fetch PC from branch/jump/trap resolution
//   instrValid/instrReady       decoder handshake on the buffer head
//   instrOut/instrPc            head instruction (NOP when invalid) and its PC
//   fetchFault                  sticky misaligned-redirect flag
module rv32i_fetch_unit
  import rv32i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemGnt,
  input  logic            imemRvalid,
  input  logic [XLEN-1:0] imemRdata,
  input  logic            redirectValid,
  input  logic [XLEN-1:0] redirectPc,
  output logic            instrValid,
  input  logic            instrReady,
  output logic [XLEN-1:0] instrOut,
  output logic [XLEN-1:0] instrPc,
  output logic            fetchFault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] fetch_pc, pc_next;
  logic            fault, fault_next;
  logic [CW-1:0]   fifo_count, count_next;
  logic            push, pop, flush, gnt_taken;
  logic [XLEN-1:0] redir_pc;
  logic            redir_misaligned;
  fetch_entry_t    head, push_entry;

`ifdef RV32I_FETCH_MISALIGN_EN
  assign redir_misaligned = redirectPc[1:0] != 2'b00;
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirectPc[1:0];
  assign redir_misaligned    = 1'b0;
`endif
  // The request address must stay word aligned even for a faulting redirect.
  assign redir_pc = {redirectPc[XLEN-1:2], 2'b00};

  assign gnt_taken  = imemReq && imemGnt;
  assign pop        = instrValid && instrReady;
  assign push_entry = '{pc: fetch_pc, instr: imemRdata};

  always_comb begin
    state_next = state;
    pc_next    = fetch_pc;
    fault_next = fault;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirectValid) begin
      flush   = 1'b1;
      pc_next = redir_pc;
      if (redir_misaligned) begin
        fault_next = 1'b1;
        state_next = FAULT;
      end else begin
        fault_next = 1'b0;
        case (state)
          FETCH:       state_next = gnt_taken ? DRAIN : FETCH;
          // The outstanding response is stale: drop it now or drain it later.
          WAIT, DRAIN: state_next = imemRvalid ? FETCH : DRAIN;
          default:     state_next = FETCH;
        endcase
      end
    end else begin
      case (state)
        FETCH: if (gnt_taken) state_next = WAIT;
        WAIT: if (imemRvalid) begin
          push       = 1'b1;
          pc_next    = fetch_pc + 32'd4;
          state_next = FETCH;
        end
        DRAIN: if (imemRvalid) state_next = FETCH;
        default: state_next = state;
      endcase
    end
    count_next = flush ? '0 : fifo_count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      fault    <= 1'b0;
      imemReq  <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= pc_next;
      fault    <= fault_next;
      // Request only while a free slot is guaranteed for the returning word.
      imemReq  <= (state_next == FETCH) && (count_next < DEPTH_C);
    end
  end

  rv32i_fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(push_entry),
    .rdata(head),
    .count(fifo_count)
  );

  assign imemAddr   = fetch_pc;
  assign instrValid = fifo_count != '0;
  assign instrOut   = instrValid ? head.instr : RV32I_NOP;
  assign instrPc    = instrValid ? head.pc : '0;
  assign fetchFault = fault;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb/tb_rv32i_fetch_unit.sv - directed self-checking bench for rv32i_fetch_unit
module tb_rv32i_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt = 1'b0;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = 32'h0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        instrValid;
  logic        instrReady = 1'b1;
  logic [31:0] instrOut;
  logic [31:0] instrPc;
  logic        fetchFault;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;

  rv32i_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
    .imemRvalid(imemRvalid), .imemRdata(imemRdata), .redirectValid(redirectValid),
    .redirectPc(redirectPc), .instrValid(instrValid), .instrReady(instrReady),
    .instrOut(instrOut), .instrPc(instrPc), .fetchFault(fetchFault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h5A00_0000 | a;
  endfunction

  // Memory model: grants any request immediately, answers mem_lat cycles later.
  initial begin : memory_model
    bit          pend;
    logic [31:0] pend_addr;
    int          lat_cnt;
    pend = 0; pend_addr = 0; lat_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        pend = 0; imemGnt = 0; imemRvalid = 0; imemRdata = 0;
      end else begin
        imemRvalid = 0;
        if (pend) begin
          if (lat_cnt == 0) begin
            imemRvalid = 1; imemRdata = word_of(pend_addr); pend = 0;
          end else lat_cnt--;
        end
        imemGnt = 0;
        if (imemReq && !pend) begin
          imemGnt = 1; pend = 1; pend_addr = imemAddr; lat_cnt = mem_lat - 1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic reset_dut();
    rst = 1; redirectValid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0h want 0", imemReq); end
    n_checks++; if (imemAddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imemAddr); end
    n_checks++; if (instrValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", instrValid); end
    n_checks++; if (instrOut !== NOP) begin n_fail++; $display("FAIL reset_out: got %h want %h", instrOut, NOP); end
    n_checks++; if (instrPc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", instrPc); end
    n_checks++; if (fetchFault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %0h want 0", fetchFault); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc, exp_addr;
    int words;
    mem_lat = 1; instrReady = 1;
    reset_dut();
    @(negedge clk); // cycle N: first request granted
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin n_fail++; $display("FAIL stream_first_req: got req=%0h addr=%h want 1/0", imemReq, imemAddr); end
    n_checks++; if (instrValid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_n: got %0h want 0", instrValid); end
    @(negedge clk); // N+1
    n_checks++; if (instrValid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_n1: got %0h want 0", instrValid); end
    exp_pc = 0; exp_addr = 4; words = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imemGnt) begin
        n_checks++; if (imemAddr !== exp_addr) begin n_fail++; $display("FAIL stream_addr: got %h want %h", imemAddr, exp_addr); end
        exp_addr += 4;
      end
      if (instrValid) begin
        n_checks++; if (instrPc !== exp_pc || instrOut !== word_of(exp_pc)) begin n_fail++; $display("FAIL stream_word: got pc=%h instr=%h want pc=%h instr=%h", instrPc, instrOut, exp_pc, word_of(exp_pc)); end
        exp_pc += 4; words++;
      end else begin
        n_checks++; if (instrOut !== NOP) begin n_fail++; $display("FAIL stream_nop: got %h want %h", instrOut, NOP); end
      end
    end
    n_checks++; if (words != 10) begin n_fail++; $display("FAIL stream_rate: got %0d words want 10", words); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    int words;
    mem_lat = 1; instrReady = 0;
    reset_dut();
    repeat (2) @(negedge clk); // N, N+1
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); // N+2 .. N+11
      n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h0 || instrOut !== word_of(32'h0)) begin n_fail++; $display("FAIL bp_head_stable: got v=%0h pc=%h instr=%h want 1/0/%h", instrValid, instrPc, instrOut, word_of(32'h0)); end
    end
    n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL bp_req_full: got %0h want 0", imemReq); end
    instrReady = 1; // pc 0 leaves at the coming edge
    exp_pc = 4; words = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); // N+12 .. N+22
      if (instrValid) begin
        n_checks++; if (instrPc !== exp_pc || instrOut !== word_of(exp_pc)) begin n_fail++; $display("FAIL bp_drain_word: got pc=%h instr=%h want pc=%h", instrPc, instrOut, exp_pc); end
        exp_pc += 4; words++;
      end
    end
    n_checks++; if (words != 6) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 6", words); end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 4; instrReady = 1;
    reset_dut();
    @(negedge clk); // N: granted
    n_checks++; if (imemReq !== 1'b1) begin n_fail++; $display("FAIL rw_req: got %0h want 1", imemReq); end
    @(negedge clk); // N+1: WAIT
    redirectValid = 1; redirectPc = 32'h0000_0100;
    @(negedge clk); // N+2
    redirectValid = 0; mem_lat = 1;
    n_checks++; if (instrValid !== 1'b0 || imemReq !== 1'b0 || imemAddr !== 32'h100) begin n_fail++; $display("FAIL rw_after: got v=%0h req=%0h addr=%h want 0/0/100", instrValid, imemReq, imemAddr); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); // N+3, N+4 (stale data returns at N+4)
      n_checks++; if (instrValid !== 1'b0 || imemReq !== 1'b0) begin n_fail++; $display("FAIL rw_drain: got v=%0h req=%0h want 0/0", instrValid, imemReq); end
    end
    @(negedge clk); // N+5
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin n_fail++; $display("FAIL rw_restart: got req=%0h addr=%h want 1/100", imemReq, imemAddr); end
    repeat (2) @(negedge clk); // N+7
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h100 || instrOut !== word_of(32'h100)) begin n_fail++; $display("FAIL rw_word: got v=%0h pc=%h instr=%h want 1/100/%h", instrValid, instrPc, instrOut, word_of(32'h100)); end
  endtask

  task automatic test_redirect_same_cycle();
    mem_lat = 1; instrReady = 1;
    reset_dut();
    repeat (2) @(negedge clk); // N+1: rvalid present
    redirectValid = 1; redirectPc = 32'h0000_0040;
    @(negedge clk); // N+2
    redirectValid = 0;
    n_checks++; if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h40) begin n_fail++; $display("FAIL rv_restart: got v=%0h req=%0h addr=%h want 0/1/40", instrValid, imemReq, imemAddr); end
    @(negedge clk); // N+3
    n_checks++; if (instrValid !== 1'b0) begin n_fail++; $display("FAIL rv_no_stale: got %0h want 0", instrValid); end
    @(negedge clk); // N+4
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h40 || instrOut !== word_of(32'h40)) begin n_fail++; $display("FAIL rv_word: got v=%0h pc=%h instr=%h want 1/40", instrValid, instrPc, instrOut); end

    reset_dut();
    @(negedge clk); // N: grant present
    redirectValid = 1; redirectPc = 32'h0000_0080;
    @(negedge clk); // N+1: draining
    redirectValid = 0;
    n_checks++; if (imemReq !== 1'b0 || instrValid !== 1'b0) begin n_fail++; $display("FAIL rg_drain: got req=%0h v=%0h want 0/0", imemReq, instrValid); end
    @(negedge clk); // N+2
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h80 || instrValid !== 1'b0) begin n_fail++; $display("FAIL rg_restart: got req=%0h addr=%h v=%0h want 1/80/0", imemReq, imemAddr, instrValid); end
    @(negedge clk); // N+3
    n_checks++; if (instrValid !== 1'b0) begin n_fail++; $display("FAIL rg_no_stale: got %0h want 0", instrValid); end
    @(negedge clk); // N+4
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h80 || instrOut !== word_of(32'h80)) begin n_fail++; $display("FAIL rg_word: got v=%0h pc=%h instr=%h want 1/80", instrValid, instrPc, instrOut); end
  endtask

  task automatic test_misalign();
    mem_lat = 1; instrReady = 1;
    reset_dut();
    repeat (2) @(negedge clk); // N+1
    redirectValid = 1; redirectPc = 32'h0000_0102;
    @(negedge clk); // N+2
    redirectValid = 0;
`ifdef RV32I_FETCH_MISALIGN_EN
    n_checks++; if (fetchFault !== 1'b1 || imemReq !== 1'b0 || instrValid !== 1'b0) begin n_fail++; $display("FAIL ma_fault: got f=%0h req=%0h v=%0h want 1/0/0", fetchFault, imemReq, instrValid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); // N+3 .. N+5
      n_checks++; if (fetchFault !== 1'b1 || imemReq !== 1'b0) begin n_fail++; $display("FAIL ma_sticky: got f=%0h req=%0h want 1/0", fetchFault, imemReq); end
    end
`else
    n_checks++; if (fetchFault !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h100) begin n_fail++; $display("FAIL ma_forced: got f=%0h req=%0h addr=%h want 0/1/100", fetchFault, imemReq, imemAddr); end
    repeat (2) @(negedge clk); // N+4
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h100) begin n_fail++; $display("FAIL ma_word: got v=%0h pc=%h want 1/100", instrValid, instrPc); end
    @(negedge clk); // N+5
`endif
    redirectValid = 1; redirectPc = 32'h0000_0200;
    @(negedge clk); // N+6
    redirectValid = 0;
    n_checks++; if (fetchFault !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h200) begin n_fail++; $display("FAIL ma_resume: got f=%0h req=%0h addr=%h want 0/1/200", fetchFault, imemReq, imemAddr); end
    repeat (2) @(negedge clk); // N+8
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h200 || instrOut !== word_of(32'h200)) begin n_fail++; $display("FAIL ma_resume_word: got v=%0h pc=%h instr=%h want 1/200", instrValid, instrPc, instrOut); end
  endtask

  task automatic test_reset_in_drain();
    mem_lat = 4; instrReady = 1;
    reset_dut();
    @(negedge clk); // N: grant present
    redirectValid = 1; redirectPc = 32'h0000_0080;
    @(negedge clk); // N+1: DRAIN, second redirect
    redirectPc = 32'h0000_00C0;
    @(negedge clk); // N+2
    redirectValid = 0;
    n_checks++; if (imemReq !== 1'b0 || imemAddr !== 32'hC0) begin n_fail++; $display("FAIL dr_second: got req=%0h addr=%h want 0/c0", imemReq, imemAddr); end
    mem_lat = 1; rst = 1;
    @(negedge clk); // N+3: in reset
    n_checks++; if (imemReq !== 1'b0 || imemAddr !== 32'h0 || instrValid !== 1'b0) begin n_fail++; $display("FAIL dr_reset_mem: got req=%0h addr=%h v=%0h want 0/0/0", imemReq, imemAddr, instrValid); end
    n_checks++; if (instrOut !== NOP || instrPc !== 32'h0 || fetchFault !== 1'b0) begin n_fail++; $display("FAIL dr_reset_out: got instr=%h pc=%h f=%0h want %h/0/0", instrOut, instrPc, fetchFault, NOP); end
    rst = 0;
    @(negedge clk); // N+4
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin n_fail++; $display("FAIL dr_restart: got req=%0h addr=%h want 1/0", imemReq, imemAddr); end
    repeat (2) @(negedge clk); // N+6
    n_checks++; if (instrValid !== 1'b1 || instrPc !== 32'h0 || instrOut !== word_of(32'h0)) begin n_fail++; $display("FAIL dr_word: got v=%0h pc=%h instr=%h want 1/0", instrValid, instrPc, instrOut); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_misalign();
    test_reset_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
